ohfsm_seq: RTL and testbench

Parametrised one-hot state sequencer, the successor to the fixed 4-state ring FSM. It walks N one-hot states in either direction. Each state is held for a programmable dwell time. It also supports enable/hold, a synchronous jump to any state, and illegal-state detection with automatic recovery. It drives phase-select and strobe sequencing in the datapath, with the one-hot vector used directly as select lines and the binary index used for muxing and debug.

---
 rtl/ohfsm_seq.sv | 149 ++++++++++++++
 tb/tb_ohfsm_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ohfsm_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ohfsm_seq
//  Description : Parametrised one-hot state sequencer. It walks N one-hot
//                states up or down, holding each state for dwell+1 enabled
//                cycles. It supports enable/hold and a synchronous jump
//                (load). When the state register is not a legal one-hot
//                state, the sequencer returns to s0 and raises a sticky error.
//  Ports       : clk       - rising-edge clock
//                rst_n     - asynchronous active-low reset
//                en        - advance enable (low = freeze state and count)
//                dir       - 0 = up (s0->s1->...), 1 = down
//                dwell     - cycles per state minus one, sampled every cycle
//                load      - synchronous jump request
//                load_idx  - jump target index (>= N jumps to s0, sets err)
//                err_clr   - clears the sticky error flag
//                state_oh  - one-hot state vector (bit i = state si)
//                idx       - binary index of the current state
//                step      - one-cycle pulse on each advance-driven change
//                wrap      - one-cycle pulse when an advance crosses the ring
//                err       - sticky error flag
//  Revision    : 1.0 - initial release
// ============================================================================
module ohfsm_seq #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N),
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            dir,
  input  logic [DW-1:0]   dwell,
  input  logic            load,
  input  logic [IDXW-1:0] load_idx,
  input  logic            err_clr,
  output logic [N-1:0]    state_oh,
  output logic [IDXW-1:0] idx,
  output logic            step,
  output logic            wrap,
  output logic            err
);

  localparam logic [IDXW:0]   C_N    = (IDXW+1)'(N);
  localparam logic [IDXW-1:0] C_LAST = IDXW'(N-1);
  localparam logic [N-1:0]    C_ONE  = N'(1);

  logic [N-1:0]    r_state_oh;
  logic [IDXW-1:0] r_idx;
  logic [DW-1:0]   r_cnt;
  logic            r_step;
  logic            r_wrap;
  logic            r_err;

  logic [N-1:0]    w_nxt_state;
  logic [IDXW-1:0] w_nxt_idx;
  logic [DW-1:0]   w_nxt_cnt;
  logic            w_nxt_step;
  logic            w_nxt_wrap;
  logic            w_nxt_err;
  logic            w_err_set;
  logic [N-1:0]    w_idx_oh;
  logic            w_legal;

  // The state is legal only when the one-hot vector is exactly the decode of
  // idx. The nonzero test also rejects idx >= N, whose decode shifts out to 0.
  assign w_idx_oh = C_ONE << r_idx;
  assign w_legal  = (r_state_oh == w_idx_oh) && (|r_state_oh);

  always_comb begin
    w_nxt_state = r_state_oh;
    w_nxt_idx   = r_idx;
    w_nxt_cnt   = r_cnt;
    w_nxt_step  = 1'b0;
    w_nxt_wrap  = 1'b0;
    w_err_set   = 1'b0;

    if (load) begin
      w_nxt_cnt = '0;
      if ({1'b0, load_idx} < C_N) begin
        w_nxt_state = C_ONE << load_idx;
        w_nxt_idx   = load_idx;
      end else begin
        w_nxt_state = C_ONE;
        w_nxt_idx   = '0;
        w_err_set   = 1'b1;
      end
    end else if (!w_legal) begin
      w_nxt_state = C_ONE;
      w_nxt_idx   = '0;
      w_nxt_cnt   = '0;
      w_err_set   = 1'b1;
    end else if (en) begin
      // >= rather than == so that lowering dwell mid-state takes effect at once
      if (r_cnt >= dwell) begin
        w_nxt_cnt  = '0;
        w_nxt_step = 1'b1;
        if (!dir) begin
          w_nxt_state = {r_state_oh[N-2:0], r_state_oh[N-1]};
          if (r_idx == C_LAST) begin
            w_nxt_idx  = '0;
            w_nxt_wrap = 1'b1;
          end else begin
            w_nxt_idx = r_idx + 1'b1;
          end
        end else begin
          w_nxt_state = {r_state_oh[0], r_state_oh[N-1:1]};
          if (r_idx == '0) begin
            w_nxt_idx  = C_LAST;
            w_nxt_wrap = 1'b1;
          end else begin
            w_nxt_idx = r_idx - 1'b1;
          end
        end
      end else begin
        w_nxt_cnt = r_cnt + 1'b1;
      end
    end

    // A set in the same cycle as a clear wins.
    w_nxt_err = w_err_set | (r_err & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_oh <= C_ONE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_step     <= 1'b0;
      r_wrap     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state_oh <= w_nxt_state;
      r_idx      <= w_nxt_idx;
      r_cnt      <= w_nxt_cnt;
      r_step     <= w_nxt_step;
      r_wrap     <= w_nxt_wrap;
      r_err      <= w_nxt_err;
    end
  end

  assign state_oh = r_state_oh;
  assign idx      = r_idx;
  assign step     = r_step;
  assign wrap     = r_wrap;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ohfsm_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ohfsm_seq
//  Description : Directed self-checking bench for ohfsm_seq. One instance
//                with N=4 and one with N=5 share clock, reset and the
//                control inputs; each test checks only the instance it
//                targets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ohfsm_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic [7:0] dwell;
  logic       load;
  logic       err_clr;

  logic [1:0] load_idx4;
  logic [3:0] state4;
  logic [1:0] idx4;
  logic       step4, wrap4, err4;

  logic [2:0] load_idx5;
  logic [4:0] state5;
  logic [2:0] idx5;
  logic       step5, wrap5, err5;

  int n_checks = 0;
  int n_errors = 0;

  ohfsm_seq #(.N(4), .DW(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .dwell(dwell),
    .load(load), .load_idx(load_idx4), .err_clr(err_clr),
    .state_oh(state4), .idx(idx4), .step(step4), .wrap(wrap4), .err(err4)
  );

  ohfsm_seq #(.N(5), .DW(8)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .dwell(dwell),
    .load(load), .load_idx(load_idx5), .err_clr(err_clr),
    .state_oh(state5), .idx(idx5), .step(step5), .wrap(wrap5), .err(err5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] exp5;
    logic [3:0] exp4;
    int         ei;

    rst_n = 1'b0; en = 1'b0; dir = 1'b0; dwell = 8'd0; load = 1'b0;
    err_clr = 1'b0; load_idx4 = 2'd0; load_idx5 = 3'd0;
    #12;
    check("rst_state", 32'(state4), 32'h1);
    check("rst_idx",   32'(idx4),   32'h0);
    check("rst_step",  32'(step4),  32'h0);
    check("rst_wrap",  32'(wrap4),  32'h0);
    check("rst_err",   32'(err4),   32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // N=4, dwell=0, up: a change on every edge, wrap on 3->0
    dwell = 8'd0; dir = 1'b0; en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      ei   = k % 4;
      exp4 = 4'b0001 << ei;
      check("up4_state", 32'(state4), 32'(exp4));
      check("up4_idx",   32'(idx4),   32'(ei));
      check("up4_step",  32'(step4),  32'h1);
      check("up4_wrap",  32'(wrap4),  32'(k == 4));
    end

    // N=5, dwell=2, down: 3 cycles per state, wrap only on 0->4, lap of 15
    do_reset();
    dwell = 8'd2; dir = 1'b1; en = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      ei   = (5 - (e / 3)) % 5;
      exp5 = 5'b00001 << ei;
      check("dn5_state", 32'(state5), 32'(exp5));
      check("dn5_idx",   32'(idx5),   32'(ei));
      check("dn5_step",  32'(step5),  32'(e % 3 == 0));
      check("dn5_wrap",  32'(wrap5),  32'(e == 3));
    end

    // Hold mid-dwell: cnt=1, dwell=3, four frozen cycles, then three more edges
    do_reset();
    dwell = 8'd3; dir = 1'b0; en = 1'b1;
    tick();
    check("hold_pre_idx", 32'(idx5), 32'h0);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hold_idx",  32'(idx5),  32'h0);
      check("hold_step", 32'(step5), 32'h0);
    end
    en = 1'b1;
    tick();
    check("resume1_idx", 32'(idx5), 32'h0);
    tick();
    check("resume2_idx",  32'(idx5),  32'h0);
    check("resume2_step", 32'(step5), 32'h0);
    tick();
    check("resume3_idx",  32'(idx5),  32'h1);
    check("resume3_step", 32'(step5), 32'h1);

    // Load to s2 mid-dwell, then an out-of-range load, then err_clr
    do_reset();
    dwell = 8'd3; dir = 1'b0; en = 1'b1;
    tick();
    load = 1'b1; load_idx5 = 3'd2;
    tick();
    check("load_state", 32'(state5), 32'h04);
    check("load_idx",   32'(idx5),   32'h2);
    check("load_step",  32'(step5),  32'h0);
    check("load_wrap",  32'(wrap5),  32'h0);
    check("load_err",   32'(err5),   32'h0);
    load = 1'b0;
    tick(); tick(); tick();
    check("load_dwell_idx", 32'(idx5), 32'h2);
    tick();
    check("load_adv_idx",  32'(idx5),  32'h3);
    check("load_adv_step", 32'(step5), 32'h1);
    load = 1'b1; load_idx5 = 3'd7;
    tick();
    check("oor_state", 32'(state5), 32'h01);
    check("oor_idx",   32'(idx5),   32'h0);
    check("oor_err",   32'(err5),   32'h1);
    load = 1'b0; en = 1'b0; err_clr = 1'b1;
    tick();
    check("clr_err", 32'(err5), 32'h0);
    err_clr = 1'b0;

    // Illegal state on N=4 with en low: recovery in one edge, sticky err
    do_reset();
    en = 1'b0; dwell = 8'd0;
    force u_dut4.r_state_oh = 4'b0110;
    #1;
    release u_dut4.r_state_oh;
    check("ill_forced", 32'(state4), 32'h6);
    tick();
    check("ill_state", 32'(state4), 32'h1);
    check("ill_idx",   32'(idx4),   32'h0);
    check("ill_err",   32'(err4),   32'h1);
    check("ill_step",  32'(step4),  32'h0);
    tick();
    check("ill_sticky", 32'(err4), 32'h1);
    err_clr = 1'b1;
    tick();
    check("ill_clr", 32'(err4), 32'h0);
    force u_dut4.r_state_oh = 4'b0110;
    #1;
    release u_dut4.r_state_oh;
    tick();
    check("ill_setwins_err",   32'(err4),   32'h1);
    check("ill_setwins_state", 32'(state4), 32'h1);
    tick();
    check("ill_clr2", 32'(err4), 32'h0);
    err_clr = 1'b0;

    // Asynchronous reset between edges
    do_reset();
    dwell = 8'd0; dir = 1'b0; en = 1'b1;
    tick(); tick(); tick();
    check("arst_pre_idx",  32'(idx5),  32'h3);
    check("arst_pre_step", 32'(step5), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state5), 32'h01);
    check("arst_idx",   32'(idx5),   32'h0);
    check("arst_step",  32'(step5),  32'h0);
    check("arst_state4", 32'(state4), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
